arithmetic_unit: RTL and testbench

ARITHMETIC_UNIT -- requirements
Module: arithmetic_unit

---
 rtl/arithmetic_unit.sv | 75 +++++++
 tb/tb_arithmetic_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/arithmetic_unit.sv
// arithmetic_unit: single-cycle unsigned add/sub/mul/div with one registered result.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset; clears Result immediately
//   Opcode    operation select: 0 add, 1 sub, 2 mul, 3 div, above 3 -> zero
//   Operand1  first unsigned operand
//   Operand2  second unsigned operand
//   Result    registered result, updated on every rising edge
module arithmetic_unit #(
  parameter int unsigned OPCODE_L  = 2,
  parameter int unsigned OPERAND_L = 32,
  parameter int unsigned RES_L     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_L-1:0]  Opcode,
  input  logic [OPERAND_L-1:0] Operand1,
  input  logic [OPERAND_L-1:0] Operand2,
  output logic [RES_L-1:0]     Result
);

  // Add/sub run one bit wider than the wider of operand and result so the
  // wrap happens only at the final truncation to RES_L bits.
  localparam int unsigned SUM_L  = ((OPERAND_L > RES_L) ? OPERAND_L : RES_L) + 1;
  localparam int unsigned PROD_L = 2 * OPERAND_L;

  localparam logic [OPCODE_L-1:0] OP_ADD = OPCODE_L'(0);
  localparam logic [OPCODE_L-1:0] OP_SUB = OPCODE_L'(1);
  localparam logic [OPCODE_L-1:0] OP_MUL = OPCODE_L'(2);
  localparam logic [OPCODE_L-1:0] OP_DIV = OPCODE_L'(3);

  logic [SUM_L-1:0]     opa_c;
  logic [SUM_L-1:0]     opb_c;
  logic [SUM_L-1:0]     sum_c;
  logic [SUM_L-1:0]     diff_c;
  logic [PROD_L-1:0]    prod_c;
  logic [OPERAND_L-1:0] quot_c;
  logic                 div_zero_c;
  logic [RES_L-1:0]     result_c;

  // Operand extension and the four candidate results.
  always_comb begin
    opa_c      = SUM_L'(Operand1);
    opb_c      = SUM_L'(Operand2);
    sum_c      = opa_c + opb_c;
    diff_c     = opa_c - opb_c;
    prod_c     = PROD_L'(Operand1) * PROD_L'(Operand2);
    div_zero_c = (Operand2 == '0);
    // Divider input is forced nonzero on a zero divisor; that quotient is unused.
    quot_c     = Operand1 / (div_zero_c ? OPERAND_L'(1) : Operand2);
  end

  // Opcode select; each cast truncates or zero-extends to RES_L.
  always_comb begin
    result_c = '0;
    case (Opcode)
      OP_ADD:  result_c = RES_L'(sum_c);
      OP_SUB:  result_c = RES_L'(diff_c);
      OP_MUL:  result_c = RES_L'(prod_c);
      OP_DIV:  result_c = div_zero_c ? {RES_L{1'b1}} : RES_L'(quot_c);
      default: result_c = '0;
    endcase
  end

  // Single output register; the async clear is the only other path into it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Result <= '0;
    end else begin
      Result <= result_c;
    end
  end

endmodule

// File: tb/tb_arithmetic_unit.sv
// Directed bench for arithmetic_unit: default widths plus a narrow/wide variant
// (OPCODE_L=3, OPERAND_L=8, RES_L=12) for out-of-range opcodes and width fitting.
module tb_arithmetic_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  opcode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] result;

  logic [2:0]  n_opcode;
  logic [7:0]  n_op1;
  logic [7:0]  n_op2;
  logic [11:0] n_result;

  int total;
  int bad;

  arithmetic_unit u_dut (
    .clk      (clk),
    .rst      (rst),
    .Opcode   (opcode),
    .Operand1 (op1),
    .Operand2 (op2),
    .Result   (result)
  );

  arithmetic_unit #(
    .OPCODE_L  (3),
    .OPERAND_L (8),
    .RES_L     (12)
  ) u_dut_n (
    .clk      (clk),
    .rst      (rst),
    .Opcode   (n_opcode),
    .Operand1 (n_op1),
    .Operand2 (n_op2),
    .Result   (n_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive default-width inputs at the falling edge, then settle past the next rising edge.
  task automatic apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode = op;
    op1    = a;
    op2    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_n(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    n_opcode = op;
    n_op1    = a;
    n_op2    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    opcode   = 2'd0;
    op1      = 32'd0;
    op2      = 32'd0;
    n_opcode = 3'd0;
    n_op1    = 8'd0;
    n_op2    = 8'd0;

    #2 rst = 1'b0;
    #1;
    check("reset", result, 0);
    check("reset_n", n_result, 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic arithmetic at default widths
    apply(2'd0, 32'd20, 32'd20);           check("add_20_20", result, 40);
    apply(2'd0, 32'hFFFF_FFFF, 32'd1);     check("add_wrap", result, 0);
    apply(2'd1, 32'd20, 32'd20);           check("sub_20_20", result, 0);
    apply(2'd1, 32'd5, 32'd7);             check("sub_wrap", result, 32'hFFFF_FFFE);
    apply(2'd2, 32'd20, 32'd20);           check("mul_20_20", result, 400);
    apply(2'd2, 32'h1_0000, 32'h1_0000);   check("mul_trunc", result, 0);
    apply(2'd2, 32'hFFFF_FFFF, 32'd3);     check("mul_low", result, 32'hFFFF_FFFD);
    apply(2'd3, 32'd20, 32'd20);           check("div_20_20", result, 1);
    apply(2'd3, 32'd7, 32'd2);             check("div_7_2", result, 3);
    apply(2'd3, 32'd9, 32'd0);             check("div_zero", result, 32'hFFFF_FFFF);
    apply(2'd3, 32'd0, 32'd0);             check("div_zero_zero", result, 32'hFFFF_FFFF);

    // Inputs changing between edges must not disturb Result
    apply(2'd0, 32'd100, 32'd23);          check("add_100_23", result, 123);
    #2;
    opcode = 2'd2;
    op1    = 32'd9;
    op2    = 32'd9;
    #1;
    check("hold_between_edges", result, 123);
    @(posedge clk);
    #1;
    check("mul_after_edge", result, 81);

    // Back-to-back inputs, one per cycle
    apply(2'd0, 32'd20, 32'd20);           check("seq_add", result, 40);
    apply(2'd1, 32'd20, 32'd20);           check("seq_sub", result, 0);
    apply(2'd2, 32'd20, 32'd20);           check("seq_mul", result, 400);
    apply(2'd3, 32'd20, 32'd20);           check("seq_div", result, 1);

    // Reset pulse between edges clears immediately and holds until the next edge
    apply(2'd0, 32'd20, 32'd20);           check("pre_reset_add", result, 40);
    #2 rst = 1'b0;
    #1;
    check("reset_immediate", result, 0);
    #2 rst = 1'b1;
    #1;
    check("reset_released_hold", result, 0);
    @(posedge clk);
    #1;
    check("reset_first_edge", result, 40);

    // Narrow operands, wider result, 3-bit opcode
    apply_n(3'd0, 8'd255, 8'd255);         check("n_add_ext", n_result, 510);
    apply_n(3'd1, 8'd5, 8'd7);             check("n_sub_wrap", n_result, 12'hFFE);
    apply_n(3'd2, 8'd255, 8'd255);         check("n_mul_trunc", n_result, 12'hE01);
    apply_n(3'd3, 8'd200, 8'd7);           check("n_div", n_result, 28);
    apply_n(3'd3, 8'd200, 8'd0);           check("n_div_zero", n_result, 12'hFFF);
    apply_n(3'd4, 8'd20, 8'd20);           check("n_op4_zero", n_result, 0);
    apply_n(3'd7, 8'd20, 8'd20);           check("n_op7_zero", n_result, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
